hdmi_rd_sched: RTL and testbench

//  Frame-buffer read scheduler for the HDMI output path. It sits between the DDR read port and the

---
 rtl/hdmi_pkg.sv | 24 ++
 rtl/hdmi_rd_addr_gen.sv | 44 ++++
 rtl/hdmi_rd_sched.sv | 146 ++++++++++++++
 tb/tb_hdmi_rd_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI frame-buffer read scheduler: FSM encoding,
// internal counter widths and the burst-length helper.
package hdmi_pkg;

    localparam int RD_LEN_W = 8;
    localparam int OFFS_W   = 32;
    localparam int STATE_W  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLR   = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd2;
    localparam logic [STATE_W-1:0] ST_REQ   = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

    // Next burst length: the full burst, or whatever is left of the frame.
    function automatic logic [RD_LEN_W-1:0] burst_len(input logic [OFFS_W-1:0] remain,
                                                      input logic [OFFS_W-1:0] max_len);
        logic [OFFS_W-1:0] pick;
        pick = (remain < max_len) ? remain : max_len;
        return pick[RD_LEN_W-1:0];
    endfunction

endpackage

// File: rtl/hdmi_rd_addr_gen.sv
// Frame walk counters: word offset into the bank, words still to fetch, and
// the length of the next burst.
module hdmi_rd_addr_gen
    import hdmi_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int BURST_LEN = 64,
    parameter int TOTAL     = 1280 * 800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                advance,
    input  logic [RD_LEN_W-1:0] adv_len,
    output logic [ADDR_W-1:0]   offset_lo,
    output logic [RD_LEN_W-1:0] len,
    output logic                last
);

    localparam logic [OFFS_W-1:0] BURST_MAX = OFFS_W'(BURST_LEN);
    localparam logic [OFFS_W-1:0] TOTAL_W   = OFFS_W'(TOTAL);

    logic [OFFS_W-1:0] offset;
    logic [OFFS_W-1:0] remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
            remain <= '0;
        end else if (init) begin
            offset <= '0;
            remain <= TOTAL_W;
        end else if (advance) begin
            offset <= offset + OFFS_W'(adv_len);
            remain <= remain - OFFS_W'(adv_len);
        end
    end

    assign len       = burst_len(remain, BURST_MAX);
    assign offset_lo = offset[ADDR_W-1:0];
    // The burst being retired empties the frame.
    assign last      = (remain == OFFS_W'(adv_len));

endmodule

// File: rtl/hdmi_rd_sched.sv
// Frame-buffer read scheduler: selects the newest completed bank per frame,
// flushes the pixel FIFO and issues burst reads while the FIFO has room.
// Optional underflow counter enabled by defining RD_UNDERFLOW_CNT_EN.
module hdmi_rd_sched
    import hdmi_pkg::*;
#(
    parameter int               ADDR_W     = 28,
    parameter int               H_DISP     = 1280,
    parameter int               V_DISP     = 800,
    parameter int               BURST_LEN  = 64,
    parameter int               FIFO_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BANK0_BASE = 28'h0000000,
    parameter logic [ADDR_W-1:0] BANK1_BASE = 28'h0100000
) (
    input  logic                            pixel_clk,
    input  logic                            sys_rst,
    input  logic                            frame_start,
    input  logic                            wr_frame_done,
    input  logic                            wr_bank,
    output logic                            rd_req,
    output logic [ADDR_W-1:0]               rd_addr,
    output logic [RD_LEN_W-1:0]             rd_len,
    input  logic                            rd_ack,
    input  logic                            rd_done,
    input  logic [$clog2(FIFO_DEPTH):0]     fifo_used,
    output logic                            fifo_clr,
    output logic                            rd_bank,
    output logic                            busy,
`ifdef RD_UNDERFLOW_CNT_EN
    input  logic                            fifo_empty,
    input  logic                            pix_rd,
    output logic [15:0]                     underflow_cnt,
`endif
    output logic [STATE_W-1:0]              state
);

    // Handshake: rd_req rises with rd_addr/rd_len already valid and holds them
    // until a cycle where rd_ack=1; the request drops on the following cycle.
    // rd_done then marks the end of that single outstanding burst.

    logic                latest_bank;
    logic                latest_vld;
    logic                pend_frame;
    logic [ADDR_W-1:0]   offset_lo;
    logic [RD_LEN_W-1:0] next_len;
    logic                last_burst;
    logic [ADDR_W-1:0]   bank_base;
    logic [OFFS_W-1:0]   used_w;
    logic                room_ok;

    hdmi_rd_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .TOTAL     (H_DISP * V_DISP)
    ) u_addr_gen (
        .clk       (pixel_clk),
        .rst       (sys_rst),
        .init      (state == ST_CLR),
        .advance   ((state == ST_WAIT) && rd_done),
        .adv_len   (rd_len),
        .offset_lo (offset_lo),
        .len       (next_len),
        .last      (last_burst)
    );

    assign bank_base = rd_bank ? BANK1_BASE : BANK0_BASE;
    assign used_w    = OFFS_W'(fifo_used);
    assign room_ok   = (used_w <= OFFS_W'(FIFO_DEPTH)) &&
                       ((OFFS_W'(FIFO_DEPTH) - used_w) >= OFFS_W'(next_len));

    assign rd_req   = (state == ST_REQ);
    assign fifo_clr = (state == ST_CLR);

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            rd_addr     <= '0;
            rd_len      <= '0;
            rd_bank     <= 1'b0;
            busy        <= 1'b0;
            latest_bank <= 1'b0;
            latest_vld  <= 1'b0;
            pend_frame  <= 1'b0;
        end else begin
            if (wr_frame_done) begin
                latest_bank <= wr_bank;
                latest_vld  <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_start) state <= ST_CLR;
                end
                ST_CLR: begin
                    if (latest_vld) rd_bank <= latest_bank;
                    busy       <= 1'b1;
                    pend_frame <= 1'b0;
                    state      <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (frame_start) begin
                        state <= ST_CLR;
                    end else if (room_ok) begin
                        rd_addr <= bank_base + offset_lo;
                        rd_len  <= next_len;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (frame_start) pend_frame <= 1'b1;
                    if (rd_ack) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A frame restart waits for the outstanding burst to land.
                    if (rd_done) begin
                        pend_frame <= 1'b0;
                        if (pend_frame || frame_start) begin
                            state <= ST_CLR;
                        end else if (last_burst) begin
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end else if (frame_start) begin
                        pend_frame <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (frame_start) state <= ST_CLR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RD_UNDERFLOW_CNT_EN
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            underflow_cnt <= '0;
        end else if (pix_rd && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_rd_sched.sv
// Directed bench for hdmi_rd_sched on a tiny 8x4 frame with 12-word bursts.
// Define RD_UNDERFLOW_CNT_EN on both RTL and bench to cover the underflow counter.
module tb_hdmi_rd_sched;
    import hdmi_pkg::*;

    localparam int ADDR_W = 28;

    logic              pixel_clk = 1'b0;
    logic              sys_rst   = 1'b1;
    logic              frame_start = 1'b0;
    logic              wr_frame_done = 1'b0;
    logic              wr_bank = 1'b0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack = 1'b0;
    logic              rd_done = 1'b0;
    logic [5:0]        fifo_used = '0;
    logic              fifo_clr;
    logic              rd_bank;
    logic              busy;
    logic [2:0]        state;
`ifdef RD_UNDERFLOW_CNT_EN
    logic              fifo_empty = 1'b0;
    logic              pix_rd = 1'b0;
    logic [15:0]       underflow_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    hdmi_rd_sched #(
        .ADDR_W     (ADDR_W),
        .H_DISP     (8),
        .V_DISP     (4),
        .BURST_LEN  (12),
        .FIFO_DEPTH (32),
        .BANK0_BASE (28'h0000000),
        .BANK1_BASE (28'h0000100)
    ) dut (
        .pixel_clk     (pixel_clk),
        .sys_rst       (sys_rst),
        .frame_start   (frame_start),
        .wr_frame_done (wr_frame_done),
        .wr_bank       (wr_bank),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_ack        (rd_ack),
        .rd_done       (rd_done),
        .fifo_used     (fifo_used),
        .fifo_clr      (fifo_clr),
        .rd_bank       (rd_bank),
        .busy          (busy),
`ifdef RD_UNDERFLOW_CNT_EN
        .fifo_empty    (fifo_empty),
        .pix_rd        (pix_rd),
        .underflow_cnt (underflow_cnt),
`endif
        .state         (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!rd_req && n < 20) begin
            step();
            n++;
        end
        check_eq("req_timeout", {31'd0, rd_req}, 32'd1);
    endtask

    // One burst: check request fields, hold ack off, accept, optionally
    // restart the frame while the burst is in flight, then complete it.
    task automatic do_burst(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                            input int ack_dly, input bit fs_wait);
        wait_req();
        check_eq("rd_addr", 32'(rd_addr), 32'(a));
        check_eq("rd_len", 32'(rd_len), 32'(l));
        for (int i = 0; i < ack_dly; i++) begin
            step();
            check_eq("hold_req", {31'd0, rd_req}, 32'd1);
            check_eq("hold_addr", 32'(rd_addr), 32'(a));
            check_eq("hold_len", 32'(rd_len), 32'(l));
        end
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check_eq("req_drop", {31'd0, rd_req}, 32'd0);
        if (fs_wait) begin
            pulse_frame_start();
            check_eq("no_req_wait", {31'd0, rd_req}, 32'd0);
        end
        step();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    initial begin
        // reset
        repeat (3) @(posedge pixel_clk);
        #2 sys_rst = 1'b0;
        step();
        check_eq("rst_req", {31'd0, rd_req}, 32'd0);
        check_eq("rst_addr", 32'(rd_addr), 32'd0);
        check_eq("rst_len", 32'(rd_len), 32'd0);
        check_eq("rst_clr", {31'd0, fifo_clr}, 32'd0);
        check_eq("rst_bank", {31'd0, rd_bank}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_state", 32'(state), 32'(ST_IDLE));
`ifdef RD_UNDERFLOW_CNT_EN
        check_eq("rst_ufl", 32'(underflow_cnt), 32'd0);
`endif

        // 1: bank 1 completed, full frame of three bursts
        wr_frame_done = 1'b1;
        wr_bank = 1'b1;
        step();
        wr_frame_done = 1'b0;
        pulse_frame_start();
        check_eq("t1_clr_on", {31'd0, fifo_clr}, 32'd1);
        step();
        check_eq("t1_clr_off", {31'd0, fifo_clr}, 32'd0);
        check_eq("t1_bank", {31'd0, rd_bank}, 32'd1);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        do_burst(28'h100, 8'd12, 0, 1'b0);
        check_eq("t1_busy_mid", {31'd0, busy}, 32'd1);
        do_burst(28'h10C, 8'd12, 0, 1'b0);
        do_burst(28'h118, 8'd8, 0, 1'b0);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
        check_eq("t1_done", 32'(state), 32'(ST_DONE));

        // 2: FIFO too full for a burst, then room appears
        fifo_used = 6'd25;
        pulse_frame_start();
        check_eq("t2_clr", {31'd0, fifo_clr}, 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t2_no_req", {31'd0, rd_req}, 32'd0);
            check_eq("t2_check", 32'(state), 32'(ST_CHECK));
        end
        fifo_used = 6'd20;
        step();
        check_eq("t2_req", {31'd0, rd_req}, 32'd1);
        check_eq("t2_len", 32'(rd_len), 32'd12);
        fifo_used = 6'd0;

        // 3: ack withheld for 10 cycles
        do_burst(28'h100, 8'd12, 10, 1'b0);

        // 4: frame restart while burst 2 is in flight
        do_burst(28'h10C, 8'd12, 0, 1'b1);
        check_eq("t4_clr", {31'd0, fifo_clr}, 32'd1);
        check_eq("t4_no_req", {31'd0, rd_req}, 32'd0);
        step();
        do_burst(28'h100, 8'd12, 0, 1'b0);

        // 5: bank 0 completes mid-frame; takes effect at the next flush
        wr_frame_done = 1'b1;
        wr_bank = 1'b0;
        step();
        wr_frame_done = 1'b0;
        check_eq("t5_bank_hold", {31'd0, rd_bank}, 32'd1);
        do_burst(28'h10C, 8'd12, 0, 1'b0);
        do_burst(28'h118, 8'd8, 0, 1'b0);
        check_eq("t5_bank_hold2", {31'd0, rd_bank}, 32'd1);
        check_eq("t5_done", 32'(state), 32'(ST_DONE));
        pulse_frame_start();
        step();
        check_eq("t5_bank_new", {31'd0, rd_bank}, 32'd0);
        do_burst(28'h000, 8'd12, 0, 1'b0);

        // 6: asynchronous reset while a request is pending
        wait_req();
        check_eq("t6_addr", 32'(rd_addr), 32'h00C);
        #2 sys_rst = 1'b1;
        #1;
        check_eq("t6_req", {31'd0, rd_req}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_state", 32'(state), 32'(ST_IDLE));
        step();
        sys_rst = 1'b0;
        step();
        check_eq("t6_idle", 32'(state), 32'(ST_IDLE));
`ifdef RD_UNDERFLOW_CNT_EN
        pix_rd = 1'b1;
        fifo_empty = 1'b0;
        step();
        check_eq("ufl_not_empty", 32'(underflow_cnt), 32'd0);
        fifo_empty = 1'b1;
        repeat (3) step();
        pix_rd = 1'b0;
        step();
        check_eq("ufl_cnt", 32'(underflow_cnt), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
